ddr4_cmd_slotter: RTL

- Sequential successor to the combinational DDR4 instruction decoder.
- Accepts one 32-bit SoftMC instruction per cycle on a valid/ready handshake.
- Decodes DDR4 commands (ACT_n, RAS/CAS/WE on A16:A14, bank, bankgroup, multi-rank CS) and packs commands into the nCK_PER_CLK phase slots of one DFI bundle.
- Executes WAIT instructions as NOP cycles; all DFI outputs are registered and sit between the instruction dispatcher and the PHY DFI.

---
 rtl/ddr4_cmd_slotter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ddr4_cmd_slotter.sv
// rtl/ddr4_cmd_slotter.sv - packs SoftMC instructions into registered DDR4 DFI phase bundles
// Commands accumulate by ascending phase; a bundle closes on last phase, phase wrap, WAIT or idle.
module ddr4_cmd_slotter #(
    parameter int ROW_WIDTH   = 17,
    parameter int BANK_WIDTH  = 2,
    parameter int BG_WIDTH    = 2,
    parameter int CS_WIDTH    = 1,
    parameter int nCK_PER_CLK = 4,
    parameter int WAIT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic [31:0]                       in_instr,
    output logic                              in_ready,
    output logic [ROW_WIDTH*nCK_PER_CLK-1:0]  dfi_address,
    output logic [BANK_WIDTH*nCK_PER_CLK-1:0] dfi_bank,
    output logic [BG_WIDTH*nCK_PER_CLK-1:0]   dfi_bankgroup,
    output logic [nCK_PER_CLK-1:0]            dfi_act_n,
    output logic [CS_WIDTH*nCK_PER_CLK-1:0]   dfi_cs_n,
    output logic [nCK_PER_CLK-1:0]            mc_rd_cas,
    output logic [nCK_PER_CLK-1:0]            mc_wr_cas,
    output logic                              bundle_valid,
    output logic                              err_sticky
);
    localparam int N  = nCK_PER_CLK;
    localparam int PW = (N > 2) ? 2 : 1;

    typedef struct packed {
        logic [ROW_WIDTH*N-1:0]  addr;
        logic [BANK_WIDTH*N-1:0] bank;
        logic [BG_WIDTH*N-1:0]   bg;
        logic [N-1:0]            act_n;
        logic [CS_WIDTH*N-1:0]   cs_n;
        logic [N-1:0]            rd;
        logic [N-1:0]            wr;
    } bundle_t;

    typedef enum logic {S_RUN, S_WAIT} state_t;

    function automatic bundle_t nop_bundle();
        bundle_t b;
        b.addr  = '0;
        b.bank  = '0;
        b.bg    = '0;
        b.act_n = '1;
        b.cs_n  = '1;
        b.rd    = '0;
        b.wr    = '0;
        return b;
    endfunction

    function automatic bundle_t put_slot(input bundle_t b, input logic [PW-1:0] p,
                                         input logic [ROW_WIDTH-1:0] a,
                                         input logic [BANK_WIDTH-1:0] ba,
                                         input logic [BG_WIDTH-1:0] bgv,
                                         input logic act_n, input logic [CS_WIDTH-1:0] cs_n,
                                         input logic rd, input logic wr);
        bundle_t r;
        r = b;
        r.addr[int'(p)*ROW_WIDTH +: ROW_WIDTH] = a;
        r.bank[int'(p)*BANK_WIDTH +: BANK_WIDTH] = ba;
        r.bg[int'(p)*BG_WIDTH +: BG_WIDTH] = bgv;
        r.act_n[p] = act_n;
        r.cs_n[int'(p)*CS_WIDTH +: CS_WIDTH] = cs_n;
        r.rd[p] = rd;
        r.wr[p] = wr;
        return r;
    endfunction

    bundle_t               acc_q, acc_d, out_q, out_d, merged, fresh;
    logic [N-1:0]          used_q, used_d, onehot;
    logic [1:0]            last_q, last_d;
    logic                  bv_q, bv_d, err_q, err_d;
    logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
    state_t                state_q, state_d;

    logic [1:0]            typ, phase, rank;
    logic                  ras_n, cas_n, we_n, is_act, slot_rd, slot_wr, drop, accept;
    logic [PW-1:0]         ph_idx;
    logic [ROW_WIDTH-1:0]  slot_addr;
    logic [CS_WIDTH-1:0]   slot_cs_n;
    logic [WAIT_WIDTH-1:0] wait_n;
    logic                  unused_instr;

    assign typ          = in_instr[31:30];
    assign phase        = in_instr[29:28];
    assign rank         = in_instr[27:26];
    assign ras_n        = in_instr[25];
    assign cas_n        = in_instr[24];
    assign we_n         = in_instr[23];
    assign wait_n       = in_instr[WAIT_WIDTH-1:0];
    assign ph_idx       = phase[PW-1:0];
    assign unused_instr = ^in_instr;

    assign is_act    = ~ras_n & cas_n & we_n;
    assign slot_rd   = ras_n & ~cas_n & we_n & ~is_act;
    assign slot_wr   = ras_n & ~cas_n & ~we_n & ~is_act;
    assign slot_addr = {(is_act ? 3'b000 : {ras_n, cas_n, we_n}), in_instr[ROW_WIDTH-4:0]};
    assign drop      = ({1'b0, phase} >= 3'(N)) || ({1'b0, rank} >= 3'(CS_WIDTH));
    assign accept    = in_valid & in_ready;

    always_comb begin
        for (int r = 0; r < CS_WIDTH; r++) slot_cs_n[r] = (rank != 2'(r));
        onehot         = '0;
        onehot[ph_idx] = 1'b1;
        merged = put_slot(acc_q, ph_idx, slot_addr, in_instr[19 +: BANK_WIDTH],
                          in_instr[21 +: BG_WIDTH], ~is_act, slot_cs_n, slot_rd, slot_wr);
        fresh  = put_slot(nop_bundle(), ph_idx, slot_addr, in_instr[19 +: BANK_WIDTH],
                          in_instr[21 +: BG_WIDTH], ~is_act, slot_cs_n, slot_rd, slot_wr);
    end

    // Accumulator / emit datapath
    always_comb begin
        acc_d  = acc_q;
        used_d = used_q;
        last_d = last_q;
        err_d  = err_q;
        out_d  = nop_bundle();
        bv_d   = 1'b0;
        if (accept) begin
            if (typ == 2'b01) begin
                if (drop) begin
                    err_d = 1'b1;
                end else if (used_q == '0 || phase > last_q) begin
                    if (phase == 2'(N-1)) begin
                        out_d  = merged;
                        bv_d   = 1'b1;
                        acc_d  = nop_bundle();
                        used_d = '0;
                    end else begin
                        acc_d  = merged;
                        used_d = used_q | onehot;
                        last_d = phase;
                    end
                end else begin
                    out_d  = acc_q;
                    bv_d   = 1'b1;
                    acc_d  = fresh;
                    used_d = onehot;
                    last_d = phase;
                end
            end else if (typ == 2'b10 && used_q != '0) begin
                out_d  = acc_q;
                bv_d   = 1'b1;
                acc_d  = nop_bundle();
                used_d = '0;
            end
        end else if (!in_valid && used_q != '0) begin
            out_d  = acc_q;
            bv_d   = 1'b1;
            acc_d  = nop_bundle();
            used_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= nop_bundle();
            out_q  <= nop_bundle();
            used_q <= '0;
            last_q <= '0;
            bv_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            out_q  <= out_d;
            used_q <= used_d;
            last_q <= last_d;
            bv_q   <= bv_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (accept && typ == 2'b10) begin
                    cnt_d = wait_n;
                    if (wait_n != '0) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - WAIT_WIDTH'(1);
                if (cnt_q == WAIT_WIDTH'(1)) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        in_ready = rst_n && (state_q == S_RUN);
    end

    assign dfi_address   = out_q.addr;
    assign dfi_bank      = out_q.bank;
    assign dfi_bankgroup = out_q.bg;
    assign dfi_act_n     = out_q.act_n;
    assign dfi_cs_n      = out_q.cs_n;
    assign mc_rd_cas     = out_q.rd;
    assign mc_wr_cas     = out_q.wr;
    assign bundle_valid  = bv_q;
    assign err_sticky    = err_q;
endmodule
